// File: rtl/pc_pkg.sv
// Shared types for the Hack-style CPU datapath: word width and the
// program-counter operation encoding.
package pc_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_LOAD  = 2'd2,
    PC_CLEAR = 2'd3
  } pc_op_e;

  // Reset beats load, and load beats inc.
  function automatic pc_op_e pc_decode(input logic reset, input logic load,
                                       input logic inc);
    if (reset)     return PC_CLEAR;
    else if (load) return PC_LOAD;
    else if (inc)  return PC_INC;
    else           return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Combinational WIDTH-bit +1 with wrap-around. Carry out is discarded.
module incrementer #(
  parameter int WIDTH = pc_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a + WIDTH'(1);

endmodule

// File: rtl/pc.sv
// Program counter: clear, load, increment or hold on each rising clk edge.
// Output comes straight from the register.
module pc
  import pc_pkg::*;
#(
  parameter int WIDTH = pc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  // Power-up value is zero even if reset is never asserted.
  logic [WIDTH-1:0] cnt = '0;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_nxt;
  pc_op_e           op;

  incrementer #(.WIDTH(WIDTH)) u_inc (
    .a (cnt),
    .y (cnt_inc)
  );

  always_comb begin
    op      = pc_decode(reset, load, inc);
    cnt_nxt = cnt;
    unique case (op)
      PC_CLEAR: cnt_nxt = '0;
      PC_LOAD:  cnt_nxt = in;
      PC_INC:   cnt_nxt = cnt_inc;
      PC_HOLD:  cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    cnt <= cnt_nxt;
  end

  assign out = cnt;

endmodule

// File: tb/tb_pc.sv
// Directed test of pc: priority, latency, wrap-around and hold stability.
module tb_pc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        inc = 1'b0;
  logic        load = 1'b0;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  pc #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .inc   (inc),
    .load  (load),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (out === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, out, exp);
    end
  endtask

  // Drive controls, take one rising edge, then settle 1 time unit after it.
  task automatic step(input logic r, input logic l, input logic i,
                      input logic [15:0] d);
    reset = r; load = l; inc = i; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("power_up", 16'h0000);

    // 1. hold and increment
    step(0, 0, 0, 16'h0000); chk("hold_zero", 16'h0000);
    step(0, 0, 1, 16'h8285); chk("inc_1", 16'h0001);
    step(0, 0, 1, 16'h8285); chk("inc_2", 16'h0002);

    // 2. load priority over inc
    step(0, 1, 1, 16'h8285); chk("load_over_inc", 16'h8285);
    step(0, 0, 1, 16'h0000); chk("inc_msb_1", 16'h8286);
    step(0, 0, 1, 16'h0000); chk("inc_msb_2", 16'h8287);
    step(0, 1, 0, 16'd12345); chk("load_12345", 16'd12345);

    // 3. reset priority
    step(1, 1, 0, 16'd12345); chk("reset_over_load", 16'h0000);
    step(0, 1, 1, 16'd12345); chk("load_after_reset", 16'd12345);
    step(1, 1, 1, 16'd12345); chk("reset_over_all", 16'h0000);
    step(0, 0, 1, 16'd12345); chk("inc_from_reset", 16'h0001);
    step(1, 0, 1, 16'd12345); chk("reset_over_inc", 16'h0000);

    // 4. load zero is a load; reset alone clears
    step(0, 0, 1, 16'h0000); chk("inc_before_load0", 16'h0001);
    step(0, 1, 1, 16'h0000); chk("load_zero", 16'h0000);
    step(0, 0, 1, 16'h0000); chk("inc_after_load0", 16'h0001);
    step(1, 0, 0, 16'd22222); chk("reset_only", 16'h0000);

    // 5. wrap-around
    step(0, 1, 0, 16'hFFFF); chk("load_ffff", 16'hFFFF);
    step(0, 0, 1, 16'h0000); chk("wrap_0", 16'h0000);
    step(0, 0, 1, 16'h0000); chk("wrap_1", 16'h0001);

    // 6. hold stability while in toggles; also no comb path in->out
    step(0, 1, 0, 16'h1234); chk("load_1234", 16'h1234);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, (k % 2 == 0) ? 16'hFFFF : 16'h5A5A);
      chk($sformatf("hold_%0d", k), 16'h1234);
    end
    load = 1'b1; inc = 1'b1; din = 16'hBEEF; reset = 1'b0;
    #2;
    chk("no_comb_path", 16'h1234);
    @(posedge clk); #1;
    chk("load_beef", 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
